// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control FSM sequencing the MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional macro RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        Zero,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        ALUScr,
  output logic        RegDst,
  output logic        RegWrite,
  output logic [3:0]  ALUControl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        busy,
  output logic        illegal,
  output logic        mem_fault
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {OP_ILL, OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ} op_t;

  state_t           state;
  state_t           state_next;
  op_t              op;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [3:0]       r_alu;
  logic             r_ok;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             accept;
  logic             mem_timeout;
  logic             unused_instr_bits;

  // Only opcode and funct are kept; the register/immediate fields go straight to the datapath.
  assign unused_instr_bits = ^instruction[25:6];

  assign instr_ready  = rst && (state == S_FETCH);
  assign accept       = instr_ready && instr_valid;
  assign IRWrite      = accept;
  assign busy         = (state != S_FETCH) && (state != S_TRAP);
  assign wait_cnt_inc = wait_cnt + 1'b1;
  // Timeout only when the final allowed MEM cycle also lacks mem_ready, so completion wins a tie.
  assign mem_timeout  = !mem_ready && (wait_cnt_inc == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
    op = OP_ILL;
    case (opcode)
      6'h00:   op = r_ok ? OP_R : OP_ILL;
      6'h08:   op = OP_ADDI;
      6'h23:   op = OP_LW;
      6'h2B:   op = OP_SW;
      6'h04:   op = OP_BEQ;
      default: op = OP_ILL;
    endcase
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    ALUScr     = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = 4'b0000;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    case (state)
      S_FETCH: begin
        if (accept) state_next = S_DECODE;
      end
      S_DECODE: begin
        PCWrite    = 1'b1;
        state_next = (op == OP_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_R: begin
            ALUControl = r_alu;
            state_next = S_WB;
          end
          OP_ADDI: begin
            ALUScr     = 1'b1;
            ALUControl = ALU_ADD;
            state_next = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUScr     = 1'b1;
            ALUControl = ALU_ADD;
            state_next = S_MEM;
          end
          OP_BEQ: begin
            ALUControl = ALU_SUB;
            PCSrc      = 1'b1;
            PCWrite    = Zero;
            state_next = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        ALUScr     = 1'b1;
        ALUControl = ALU_ADD;
        MemRead    = (op == OP_LW);
        MemWrite   = (op == OP_SW);
        if (mem_ready)        state_next = (op == OP_LW) ? S_WB : S_FETCH;
        else if (mem_timeout) state_next = S_TRAP;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
        case (op)
          OP_R: begin
            RegDst     = 1'b1;
            ALUControl = r_alu;
          end
          OP_ADDI: begin
            ALUScr     = 1'b1;
            ALUControl = ALU_ADD;
          end
          default: begin
            ALUScr     = 1'b1;
            ALUControl = ALU_ADD;
            MemToReg   = 1'b1;
          end
        endcase
      end
      default: state_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      opcode    <= '0;
      funct     <= '0;
      wait_cnt  <= '0;
      illegal   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        opcode <= instruction[31:26];
        funct  <= instruction[5:0];
      end
      if (state == S_EXEC)                    wait_cnt <= '0;
      else if (state == S_MEM && !mem_ready)  wait_cnt <= wait_cnt_inc;
      if (state == S_DECODE && op == OP_ILL)  illegal   <= 1'b1;
      if (state == S_MEM && mem_timeout)      mem_fault <= 1'b1;
    end
  end

`ifdef RETIRE_COUNT_EN
  logic retire_pulse;

  // An instruction retires on its final productive cycle; trapped instructions never reach one.
  assign retire_pulse = (state == S_WB) ||
                        (state == S_MEM && op == OP_SW && mem_ready) ||
                        (state == S_EXEC && op == OP_BEQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              retired <= '0;
    else if (retire_pulse) retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized checks of mips_multicycle_ctrl against a per-instruction summary model.
// Covers reset, every legal op, traps, MEM timeout edge and async reset; RETIRE_COUNT_EN also checks retired.
module tb_mips_multicycle_ctrl;

  localparam int MT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        zero_in = 1'b0;
  logic        IRWrite, PCWrite, PCSrc, ALUScr, RegDst, RegWrite;
  logic [3:0]  ALUControl;
  logic        MemRead, MemWrite, MemToReg, busy, illegal, mem_fault;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  int passed = 0;
  int total  = 0;
  int exp_retired = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .mem_ready(mem_ready), .Zero(zero_in),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUScr(ALUScr),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .busy(busy), .illegal(illegal), .mem_fault(mem_fault)
`ifdef RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         legal;
    bit         fault;
    int         latency;
    int         n_regwrite;
    int         n_memread;
    int         n_memwrite;
    int         n_pcwrite;
    int         n_pcsrc;
    logic [3:0] exec_alu;
    logic       exec_scr;
    logic       wb_regdst;
    logic       wb_memtoreg;
    logic       wb_scr;
    bit         chk_wb_scr;
  } exp_t;

  // Whole-instruction expectations derived from the op tables, latency rules and timeout rule.
  function automatic exp_t model(input logic [31:0] instr, input int m, input logic z);
    exp_t e;
    logic [5:0] opc;
    logic [5:0] fn;
    int mem_cycles;
    opc = instr[31:26];
    fn  = instr[5:0];
    e = '{legal: 1'b1, fault: 1'b0, latency: 0, n_regwrite: 0, n_memread: 0, n_memwrite: 0,
          n_pcwrite: 1, n_pcsrc: 0, exec_alu: 4'b0010, exec_scr: 1'b1, wb_regdst: 1'b0,
          wb_memtoreg: 1'b0, wb_scr: 1'b0, chk_wb_scr: 1'b0};
    e.fault    = (m > MT);
    mem_cycles = e.fault ? MT : m;
    if (opc == 6'h00) begin
      e.latency = 4; e.n_regwrite = 1; e.exec_scr = 1'b0; e.wb_regdst = 1'b1;
      e.chk_wb_scr = 1'b1; e.wb_scr = 1'b0; e.fault = 1'b0;
      if      (fn == 6'h20) e.exec_alu = 4'b0010;
      else if (fn == 6'h22) e.exec_alu = 4'b0110;
      else if (fn == 6'h24) e.exec_alu = 4'b0000;
      else if (fn == 6'h25) e.exec_alu = 4'b0001;
      else if (fn == 6'h2A) e.exec_alu = 4'b0111;
      else begin e.legal = 1'b0; e.n_regwrite = 0; end
    end else if (opc == 6'h08) begin
      e.latency = 4; e.n_regwrite = 1; e.chk_wb_scr = 1'b1; e.wb_scr = 1'b1; e.fault = 1'b0;
    end else if (opc == 6'h23) begin
      e.latency = 4 + m; e.n_memread = mem_cycles; e.n_regwrite = e.fault ? 0 : 1;
      e.wb_memtoreg = 1'b1;
    end else if (opc == 6'h2B) begin
      e.latency = 3 + m; e.n_memwrite = mem_cycles;
    end else if (opc == 6'h04) begin
      e.latency = 3; e.exec_alu = 4'b0110; e.exec_scr = 1'b0; e.n_pcsrc = 1;
      e.n_pcwrite = 1 + (z ? 1 : 0); e.fault = 1'b0;
    end else begin
      e.legal = 1'b0;
    end
    if (!e.legal) e.fault = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    instr_valid = 1'b1;
    mem_ready   = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("reset_outputs",
      {15'd0, instr_ready, IRWrite, PCWrite, PCSrc, ALUScr, RegDst, RegWrite, ALUControl,
       MemRead, MemWrite, MemToReg, busy, illegal, mem_fault}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    exp_retired = 0;
    rst = 1'b1;
    #1;
  endtask

  // Issue one instruction from a FETCH cycle and follow it until the next FETCH or TRAP.
  task automatic applyStimulus(input logic [31:0] instr, input int m, input logic z, output bit trapped);
    exp_t e;
    int c, memc, n_rw, n_mr, n_mw, n_pw, n_ps;
    logic [3:0] ex_alu;
    logic ex_scr, wb_rd, wb_mtr, wb_scr;
    bit done;
    e = model(instr, m, z);
    c = 0; memc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_pw = 0; n_ps = 0;
    ex_alu = 4'hx; ex_scr = 1'bx; wb_rd = 1'bx; wb_mtr = 1'bx; wb_scr = 1'bx;
    trapped = 1'b0; done = 1'b0;
    instruction = instr; instr_valid = 1'b1; zero_in = z; mem_ready = 1'b0;
    #1;
    checkOutput("accept_ready_irwrite", {30'd0, instr_ready, IRWrite}, 32'd3);
    while (!done) begin
      if (PCWrite)  n_pw++;
      if (PCSrc)    n_ps++;
      if (MemRead)  n_mr++;
      if (MemWrite) n_mw++;
      if (c == 2) begin ex_alu = ALUControl; ex_scr = ALUScr; end
      if (RegWrite) begin n_rw++; wb_rd = RegDst; wb_mtr = MemToReg; wb_scr = ALUScr; end
      if (MemRead || MemWrite) memc++;
      mem_ready = (memc != 0) && (memc == m) && (MemRead || MemWrite);
      step();
      instr_valid = 1'b0;
      mem_ready   = 1'b0;
      #1;
      c++;
      if (instr_ready) done = 1'b1;
      else if (!busy) begin trapped = 1'b1; done = 1'b1; end
      else if (c > 40) begin
        checkOutput("cycle_bound_expired", c, 32'd0);
        done = 1'b1;
      end
    end
    checkOutput("trap_taken", trapped, (!e.legal || e.fault) ? 1 : 0);
    checkOutput("illegal_flag", illegal, e.legal ? 0 : 1);
    checkOutput("mem_fault_flag", mem_fault, e.fault ? 1 : 0);
    checkOutput("pcwrite_cycles", n_pw, e.n_pcwrite);
    checkOutput("regwrite_cycles", n_rw, e.n_regwrite);
    checkOutput("memread_cycles", n_mr, e.n_memread);
    checkOutput("memwrite_cycles", n_mw, e.n_memwrite);
    if (e.legal) begin
      checkOutput("pcsrc_cycles", n_ps, e.n_pcsrc);
      checkOutput("exec_alucontrol", ex_alu, e.exec_alu);
      checkOutput("exec_aluscr", ex_scr, e.exec_scr);
      if (!e.fault) begin
        checkOutput("latency", c, e.latency);
        exp_retired++;
      end
    end
    if (e.n_regwrite > 0) begin
      checkOutput("wb_regdst", wb_rd, e.wb_regdst);
      checkOutput("wb_memtoreg", wb_mtr, e.wb_memtoreg);
      if (e.chk_wb_scr) checkOutput("wb_aluscr", wb_scr, e.wb_scr);
    end
`ifdef RETIRE_COUNT_EN
    checkOutput("retired_count", retired, exp_retired);
`endif
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] w;
    logic [5:0] bad;
    w = $urandom;
    case (kind)
      0: w = {6'h00, w[25:6], 6'h20};
      1: w = {6'h00, w[25:6], 6'h22};
      2: w = {6'h00, w[25:6], 6'h24};
      3: w = {6'h00, w[25:6], 6'h25};
      4: w = {6'h00, w[25:6], 6'h2A};
      5: w = {6'h08, w[25:0]};
      6: w = {6'h23, w[25:0]};
      7: w = {6'h2B, w[25:0]};
      8: w = {6'h04, w[25:0]};
      9: begin
        bad = 6'($urandom_range(0, 63));
        if (bad == 6'h00 || bad == 6'h08 || bad == 6'h23 || bad == 6'h2B || bad == 6'h04) bad = 6'h3F;
        w = {bad, w[25:0]};
      end
      default: w = {6'h00, w[25:6], 6'h27};
    endcase
    return w;
  endfunction

  initial begin
    bit tr;
    int kind, m;
    $display("[TB] starting mips_multicycle_ctrl bench");
    applyReset();

    applyStimulus(32'h00221820, 1, 1'b0, tr);
    applyStimulus(32'h20010005, 1, 1'b0, tr);
    applyStimulus(32'h00221822, 1, 1'b0, tr);
    applyStimulus(32'h8C220004, 3, 1'b0, tr);
    applyStimulus({6'h2B, 26'h0220004}, 1, 1'b0, tr);
    applyStimulus(32'h10220003, 1, 1'b1, tr);
    applyStimulus(32'h10220003, 1, 1'b0, tr);
    applyStimulus(32'h8C220004, MT, 1'b0, tr);
    applyStimulus({6'h2B, 26'h0220004}, MT, 1'b0, tr);

    applyStimulus(32'h8C220004, 1000, 1'b0, tr);
    applyReset();

    applyStimulus({6'h3F, 26'h0}, 1, 1'b0, tr);
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("trap_ready_held_low", {30'd0, instr_ready, busy}, 32'd0);
    end
    applyReset();
    applyStimulus({6'h00, 20'h12345, 6'h27}, 1, 1'b0, tr);
    applyReset();

    instruction = 32'h8C220004; instr_valid = 1'b1;
    #1;
    for (int i = 0; i < 10 && !MemRead; i++) begin
      step();
      instr_valid = 1'b0;
    end
    checkOutput("memread_before_reset", MemRead, 1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_memread", {30'd0, MemRead, busy}, 32'd0);
    @(posedge clk);
    #1;
    exp_retired = 0;
    rst = 1'b1;
    #1;

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 10);
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(1, 4);
      applyStimulus(rand_instr(kind), m, 1'($urandom_range(0, 1)), tr);
      if (tr) applyReset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
